// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver/transmitter state encoding and default frame geometry.
package i2s_pkg;

  localparam int unsigned DEF_RES  = 16;
  localparam int unsigned DEF_SLOT = 32;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

endpackage

// File: rtl/i2s_in_sync.sv
// Brings the asynchronous I2S pins into the clk domain and strobes each bclk rising edge.
module i2s_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic bclk,
  input  logic lrclk,
  input  logic sdata,
  output logic lrclk_s,
  output logic sdata_s,
  output logic rise_c
);

  logic [2:0] bclk_q;
  logic [1:0] lrclk_q;
  logic [1:0] sdata_q;

  // Two-stage synchronisers; bclk carries a third stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_q  <= '0;
      lrclk_q <= '0;
      sdata_q <= '0;
    end else begin
      bclk_q  <= {bclk_q[1:0], bclk};
      lrclk_q <= {lrclk_q[0], lrclk};
      sdata_q <= {sdata_q[0], sdata};
    end
  end

  assign lrclk_s = lrclk_q[1];
  assign sdata_s = sdata_q[1];
  assign rise_c  = bclk_q[1] & ~bclk_q[2];

endmodule

// File: rtl/i2s_audio_in.sv
// I2S slave receiver: captures one left/right pair per frame and offers it on valid/ready.
module i2s_audio_in
  import i2s_pkg::*;
#(
  parameter int unsigned in_res   = DEF_RES,
  parameter int unsigned max_slot = DEF_SLOT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              sdata,
  output logic [in_res-1:0] left_out,
  output logic [in_res-1:0] right_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int unsigned CW = $clog2(max_slot + 1);

  logic              lr_s;
  logic              d_s;
  logic              rise_c;
  logic              chg_c;
  logic              lr_prev;
  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx, cnt_inc;
  logic [in_res-1:0] shreg, shreg_nx;
  logic [in_res-1:0] left_hold, left_hold_nx;
  logic              publish_c;
  logic              err_c;

  i2s_in_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .sdata   (sdata),
    .lrclk_s (lr_s),
    .sdata_s (d_s),
    .rise_c  (rise_c)
  );

  assign chg_c   = lr_s ^ lr_prev;
  assign cnt_inc = (cnt == CW'(max_slot)) ? cnt : cnt + CW'(1);

  // Slot tracking: the rise that shows a word-select change carries the closing slot's last bit.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    shreg_nx     = shreg;
    left_hold_nx = left_hold;
    publish_c    = 1'b0;
    err_c        = 1'b0;
    if (rise_c) begin
      case (state)
        HUNT: begin
          if (chg_c && !lr_s) begin
            state_nx = LEFT;
            cnt_nx   = '0;
          end
        end
        LEFT, RIGHT: begin
          if (cnt < CW'(in_res)) shreg_nx = {shreg[in_res-2:0], d_s};
          cnt_nx = cnt_inc;
          if (chg_c) begin
            cnt_nx = '0;
            if (cnt_inc < CW'(in_res)) begin
              err_c    = 1'b1;
              state_nx = HUNT;
            end else if (state == LEFT) begin
              left_hold_nx = shreg_nx;
              state_nx     = RIGHT;
            end else begin
              publish_c = 1'b1;
              state_nx  = LEFT;
            end
          end else if (cnt == CW'(max_slot)) begin
            err_c    = 1'b1;
            cnt_nx   = '0;
            state_nx = HUNT;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // Receiver state, word-select history and shift/count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      lr_prev   <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      left_hold <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      shreg     <= shreg_nx;
      left_hold <= left_hold_nx;
      if (rise_c) lr_prev <= lr_s;
    end
  end

  // Output handshake: publish overwrites a pending frame, accept clears valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_out  <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= err_c;
      if (publish_c) begin
        left_out  <= left_hold;
        right_out <= shreg_nx;
        out_valid <= 1'b1;
        overrun   <= out_valid & ~out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
